// File: rtl/alu_share_arbiter.sv
// Two requesters time-share one ALU behind a one-entry registered result stage.
// Round-robin arbitration on contention; a full stage can drain and reload on the same edge.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags,
    output logic             res_id,
    input  logic             res_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             free, grant0, grant1, grant;
    logic [WIDTH-1:0] op_a, op_b, b_eff, alu_data;
    logic [1:0]       op_sel;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;

    // Grants depend only on handshake state, never on operand values.
    always_comb begin
        free   = (state == EMPTY) || res_ready;
        grant0 = reset && free && req0_valid && (!req1_valid || last_grant);
        grant1 = reset && free && req1_valid && (!req0_valid || !last_grant);
        grant  = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state == FULL);

    always_comb begin
        state_nxt = state;
        if (grant)
            state_nxt = FULL;
        else if (state == FULL && res_ready)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Single shared datapath: subtraction reuses the adder as a + ~b + 1.
    always_comb begin
        op_a   = grant1 ? req1_a  : req0_a;
        op_b   = grant1 ? req1_b  : req0_b;
        op_sel = grant1 ? req1_op : req0_op;
        b_eff  = (op_sel == 2'b01) ? ~op_b : op_b;
        sum    = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_sel == 2'b01)};
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (op_sel)
            2'b00, 2'b01: begin
                alu_data = sum[WIDTH-1:0];
                alu_c    = sum[WIDTH];
                alu_v    = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            2'b10:   alu_data = op_a & op_b;
            default: alu_data = op_a | op_b;
        endcase
        alu_flags = {alu_data[WIDTH-1], (alu_data == '0), alu_c, alu_v};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_data   <= '0;
            res_flags  <= 4'b0000;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant) begin
            res_data   <= alu_data;
            res_flags  <= alu_flags;
            res_id     <= grant1;
            last_grant <= grant1;
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-004 req0_valid, req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands of requester n.
REQ-006 req0_op, req1_op  input  2 each  ALU control: 00 add, 01 sub (a-b), 10 and, 11 or.
REQ-007 req0_ready, req1_ready  output  1 each  operation of requester n accepted this cycle when valid&ready.
REQ-008 res_valid  output  1  result register holds an undelivered result.
REQ-009 res_data  output  WIDTH  registered ALU result.
REQ-010 res_flags  output  4  registered {N,Z,C,V}.
REQ-011 res_id  output  1  requester index that produced res_data.
REQ-012 res_ready  input  1  consumer accepts result when res_valid&res_ready.

Function
REQ-013 Block SHALL time-share one ALU datapath between two requesters with a one-entry registered output stage.
REQ-014 State machine SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-015 Output stage SHALL be "free" in a cycle when state is EMPTY, or FULL with res_ready=1.
REQ-016 When free and exactly one reqN_valid=1, that requester's ready SHALL be 1 (grant to N).
REQ-017 When free and both valid, grant SHALL go to the requester not granted most recently (round-robin via last_grant register).
REQ-018 At most one reqN_ready SHALL be 1 per cycle; ready SHALL be 0 when not free or reqN_valid=0.
REQ-019 ready SHALL be combinational from valid/state/res_ready/last_grant, never from operand values.
REQ-020 On a grant, next edge SHALL load res_data, res_flags, res_id=N, set last_grant=N, enter FULL (latency 1 cycle accept-to-res_valid).
REQ-021 FULL with res_ready=1 and a grant: SHALL drain and reload same edge, remaining FULL (back-to-back throughput 1/cycle).
REQ-022 FULL with res_ready=1, no grant: SHALL go EMPTY; FULL with res_ready=0: SHALL hold all outputs stable.
REQ-023 res_ready while EMPTY SHALL be ignored.
REQ-024 Arithmetic modulo 2^WIDTH; add: C=carry-out; sub computed as a+~b+1, C=carry-out (1 = no borrow).
REQ-025 V for add/sub SHALL be signed overflow of the WIDTH-bit operation; and/or SHALL give C=0, V=0.
REQ-026 N SHALL be res_data[WIDTH-1]; Z SHALL be 1 iff res_data==0.
REQ-027 last_grant SHALL update only on a grant; non-granted requester's operation SHALL not be sampled.

Reset
REQ-028 reset=0 SHALL asynchronously force EMPTY, res_valid=0, res_data=0, res_flags=0000, res_id=0, last_grant=1 (requester 0 wins first contention).
REQ-029 reset asserted mid-operation SHALL discard the held result; reqN_ready SHALL be 0 while reset=0.
REQ-030 First grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-031 WIDTH=32, reset released, only req0 valid, add 0xFFFFFFFF+0x1, res_ready=1 -> req0_ready=1 same cycle; next cycle res_valid=1, res_data=0, flags N0 Z1 C1 V0, res_id=0.
REQ-032 Both valid every cycle, res_ready=1, req0 sub 5-7, req1 or 0xF0|0x0F -> grants alternate 0,1,0,1; results 0xFFFFFFFE flags N1 Z0 C0 V0, and 0x000000FF flags 0000.
REQ-033 Req0 add 0x7FFFFFFF+1, res_ready held 0 for 3 cycles -> res_valid=1, res_data=0x80000000, flags N1 Z0 C0 V1 stable 3 cycles, both readies 0; res_ready=1 -> drain plus next grant same edge.
REQ-034 Req1 and 0x0000FFFF&0xFFFF0000 accepted, reset pulsed low before res_ready -> res_valid=0, res_data=0 immediately; after release, simultaneous valids grant req0 first.
REQ-035 Random valid/op/operand/res_ready stream 10k cycles -> scoreboard matches reference ALU model, no lost/duplicated results, no requester waits >1 grant while other holds consecutive grants.
